// File: rtl/pe_obuffer_pkg.sv
// Shared sizing helpers for multi-lane PE output buffers: beat count, last-beat width, counter width.
package pe_obuffer_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Minimum of 1 bit so a single-beat counter still has a legal width.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_beats(input int out_channel, input int in_lanes);
    return ceil_div(out_channel, in_lanes);
  endfunction

  function automatic int calc_rem(input int out_channel, input int in_lanes);
    return out_channel - (calc_beats(out_channel, in_lanes) - 1) * in_lanes;
  endfunction

endpackage

// File: rtl/pe_incha_multi_obuffer_if.sv
// Beat-in / vector-out handshake bundle; slave modport is the buffer, master modport drives it.
interface pe_incha_multi_obuffer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_CHANNEL = 17,
  parameter int IN_LANES    = 2
);
  logic [DATA_WIDTH*IN_LANES-1:0]    i_data;
  logic                              i_valid;
  logic                              i_ready;
  logic [DATA_WIDTH*OUT_CHANNEL-1:0] o_data;
  logic                              o_valid;
  logic                              o_ready;
  logic                              o_error;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_valid, o_error
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_valid, o_error
  );
endinterface

// File: rtl/pe_obuffer_beat_counter.sv
// Wrapping beat counter 0..BEATS-1, advanced by en; is_last flags the final beat of a vector.
module pe_obuffer_beat_counter
  import pe_obuffer_pkg::*;
#(
  parameter int BEATS = 9,
  parameter int CW    = clog2_min1(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          is_last
);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign is_last = (cnt_q == LAST);
endmodule

// File: rtl/pe_incha_multi_obuffer.sv
// Packs IN_LANES-wide beats into OUT_CHANNEL vectors; o_valid 1 cycle after the last beat, only the last beat stalls.
// Optional sticky upstream-protocol error under PE_OBUFFER_PROTOCOL_CHECK_EN (o_error tied 0 otherwise).
module pe_incha_multi_obuffer
  import pe_obuffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_CHANNEL = 17,
  parameter int IN_LANES    = 2
) (
  input logic                     clk,
  input logic                     rst,
  pe_incha_multi_obuffer_if.slave bus
);
  localparam int BEATS = calc_beats(OUT_CHANNEL, IN_LANES);
  localparam int REM   = calc_rem(OUT_CHANNEL, IN_LANES);
  localparam int CW    = clog2_min1(BEATS);
  localparam int OW    = DATA_WIDTH * OUT_CHANNEL;
  localparam int BW    = DATA_WIDTH * IN_LANES;

  logic [CW-1:0] beat_cnt;
  logic          is_last;
  logic          i_ready;
  logic          accept;
  logic          load;
  logic [OW-1:0] vec_full;
  logic [OW-1:0] o_data_q, o_data_d;
  logic          o_valid_q, o_valid_d;

  // The held vector can drain and be replaced in the same cycle.
  assign i_ready = !is_last || !o_valid_q || bus.o_ready;
  assign accept  = bus.i_valid && i_ready;
  assign load    = accept && is_last;

  pe_obuffer_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .cnt     (beat_cnt),
    .is_last (is_last)
  );

  generate
    if (BEATS > 1) begin : g_coll
      localparam int CCW = (BEATS - 1) * BW;
      logic [CCW-1:0] coll_q, coll_d;

      always_comb begin
        coll_d = coll_q;
        for (int b = 0; b < BEATS - 1; b++) begin
          if (accept && beat_cnt == CW'(b)) coll_d[b*BW +: BW] = bus.i_data;
        end
      end

      // Pure datapath: every channel is rewritten before it can reach o_data.
      always_ff @(posedge clk) begin
        coll_q <= coll_d;
      end

      assign vec_full = {bus.i_data[REM*DATA_WIDTH-1:0], coll_q};
    end else begin : g_single
      assign vec_full = bus.i_data[OW-1:0];
    end
  endgenerate

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    if (load) begin
      o_valid_d = 1'b1;
      o_data_d  = vec_full;
    end else if (bus.o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign bus.i_ready = i_ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;

`ifdef PE_OBUFFER_PROTOCOL_CHECK_EN
  logic          stall_q, stall_d;
  logic          err_q, err_d;
  logic [BW-1:0] held_q, held_d;

  // A stalled beat must be re-presented unchanged on the following cycle.
  always_comb begin
    stall_d = bus.i_valid && !i_ready;
    held_d  = bus.i_data;
    err_d   = err_q || (stall_q && (!bus.i_valid || bus.i_data != held_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      held_q  <= '0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
      held_q  <= held_d;
    end
  end

  assign bus.o_error = err_q;
`else
  assign bus.o_error = 1'b0;
`endif
endmodule

// File: tb/tb_pe_incha_multi_obuffer.sv
// Directed bench for three buffer shapes: 17ch/2 lanes, 16ch/4 lanes, and the single-beat 4ch/4 lanes.
module tb_pe_incha_multi_obuffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef PE_OBUFFER_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  pe_incha_multi_obuffer_if #(.DATA_WIDTH(8), .OUT_CHANNEL(17), .IN_LANES(2)) b17 ();
  pe_incha_multi_obuffer_if #(.DATA_WIDTH(8), .OUT_CHANNEL(16), .IN_LANES(4)) b16 ();
  pe_incha_multi_obuffer_if #(.DATA_WIDTH(8), .OUT_CHANNEL(4),  .IN_LANES(4)) b4 ();

  pe_incha_multi_obuffer #(.DATA_WIDTH(8), .OUT_CHANNEL(17), .IN_LANES(2)) u17 (
    .clk(clk), .rst(rst), .bus(b17)
  );
  pe_incha_multi_obuffer #(.DATA_WIDTH(8), .OUT_CHANNEL(16), .IN_LANES(4)) u16 (
    .clk(clk), .rst(rst), .bus(b16)
  );
  pe_incha_multi_obuffer #(.DATA_WIDTH(8), .OUT_CHANNEL(4), .IN_LANES(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Vector k carries channel c = k*32 + c; beat b lane l carries channel b*lanes + l.
  function automatic logic [15:0] beat17(input int k, input int b);
    logic [7:0] l0, l1;
    l0 = 8'(k * 32 + 2 * b);
    l1 = 8'(k * 32 + 2 * b + 1);
    return {l1, l0};
  endfunction

  function automatic logic [135:0] vec17(input int k);
    logic [135:0] v;
    for (int c = 0; c < 17; c++) v[c*8 +: 8] = 8'(k * 32 + c);
    return v;
  endfunction

  function automatic logic [31:0] beat16(input int k, input int b);
    logic [31:0] d;
    for (int l = 0; l < 4; l++) d[l*8 +: 8] = 8'(k * 32 + 4 * b + l);
    return d;
  endfunction

  function automatic logic [127:0] vec16(input int k);
    logic [127:0] v;
    for (int c = 0; c < 16; c++) v[c*8 +: 8] = 8'(k * 32 + c);
    return v;
  endfunction

  task automatic idle_all();
    b17.i_valid = 1'b0; b17.i_data = '0; b17.o_ready = 1'b0;
    b16.i_valid = 1'b0; b16.i_data = '0; b16.o_ready = 1'b0;
    b4.i_valid  = 1'b0; b4.i_data  = '0; b4.o_ready  = 1'b0;
  endtask

  // One cycle on the 17/2 buffer: drive, check i_ready before the edge, return just after it.
  task automatic cyc17(input logic vld, input logic [15:0] d, input logic ordy,
                       input logic exp_irdy, input string nm);
    b17.i_valid = vld;
    b17.i_data  = d;
    b17.o_ready = ordy;
    @(negedge clk);
    chk({nm, ".i_ready"}, b17.i_ready, exp_irdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        ordy;
    logic        exp_irdy;
    logic        exp_ovld;
    logic [31:0] exp_dat;
  } row_t;

  row_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 32'h04030201, 1'b1, 1'b1, 1'b1, 32'h04030201};
    tbl[1] = '{1'b1, 32'h14131211, 1'b0, 1'b0, 1'b1, 32'h04030201};
    tbl[2] = '{1'b1, 32'h14131211, 1'b0, 1'b0, 1'b1, 32'h04030201};
    tbl[3] = '{1'b1, 32'h14131211, 1'b1, 1'b1, 1'b1, 32'h14131211};
    tbl[4] = '{1'b0, 32'h14131211, 1'b1, 1'b1, 1'b0, 32'h14131211};
    tbl[5] = '{1'b0, 32'h14131211, 1'b0, 1'b1, 1'b0, 32'h14131211};
    tbl[6] = '{1'b1, 32'h24232221, 1'b0, 1'b1, 1'b1, 32'h24232221};
    tbl[7] = '{1'b0, 32'h24232221, 1'b0, 1'b0, 1'b1, 32'h24232221};
    tbl[8] = '{1'b0, 32'h24232221, 1'b1, 1'b1, 1'b0, 32'h24232221};
    tbl[9] = '{1'b1, 32'h34333231, 1'b1, 1'b1, 1'b1, 32'h34333231};

    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.o_valid17", b17.o_valid, 1'b0);
    chk("rst.o_data17",  b17.o_data, '0);
    chk("rst.o_error17", b17.o_error, 1'b0);
    chk("rst.i_ready17", b17.i_ready, 1'b1);
    chk("rst.i_ready4",  b4.i_ready, 1'b1);
    chk("rst.o_valid16", b16.o_valid, 1'b0);
    @(posedge clk);
    #1;

    // Single vector, free-flowing output; lane1 of the last beat is dropped
    for (int b = 0; b < 9; b++) begin
      cyc17(1'b1, beat17(0, b), 1'b1, 1'b1, "t1.beat");
      if (b < 8) chk("t1.o_valid_early", b17.o_valid, 1'b0);
    end
    chk("t1.o_valid", b17.o_valid, 1'b1);
    chk("t1.o_data", b17.o_data, vec17(0));
    cyc17(1'b0, '0, 1'b1, 1'b1, "t1.idle");
    chk("t1.pulse_end", b17.o_valid, 1'b0);

    // Backpressure: second vector stalls only on its last beat, then drain+load
    for (int b = 0; b < 9; b++) cyc17(1'b1, beat17(1, b), 1'b0, 1'b1, "t3.v1");
    chk("t3.v1_valid", b17.o_valid, 1'b1);
    chk("t3.v1_data", b17.o_data, vec17(1));
    for (int b = 0; b < 8; b++) begin
      cyc17(1'b1, beat17(2, b), 1'b0, 1'b1, "t3.v2");
      chk("t3.v1_hold", b17.o_data, vec17(1));
    end
    for (int i = 0; i < 3; i++) begin
      cyc17(1'b1, beat17(2, 8), 1'b0, 1'b0, "t3.stall");
      chk("t3.stall_valid", b17.o_valid, 1'b1);
      chk("t3.stall_data", b17.o_data, vec17(1));
    end
    cyc17(1'b1, beat17(2, 8), 1'b1, 1'b1, "t3.drain_load");
    chk("t3.dl_valid", b17.o_valid, 1'b1);
    chk("t3.dl_data", b17.o_data, vec17(2));
    cyc17(1'b0, '0, 1'b1, 1'b1, "t3.idle");
    chk("t3.idle_valid", b17.o_valid, 1'b0);
    chk("t3.no_error", b17.o_error, 1'b0);

    // Upstream changes data while stalled on the last beat
    for (int b = 0; b < 9; b++) cyc17(1'b1, beat17(3, b), 1'b0, 1'b1, "t6.v3");
    for (int b = 0; b < 8; b++) cyc17(1'b1, beat17(4, b), 1'b0, 1'b1, "t6.v4");
    cyc17(1'b1, beat17(4, 8), 1'b0, 1'b0, "t6.stall");
    chk("t6.err_before", b17.o_error, 1'b0);
    cyc17(1'b1, beat17(4, 8) ^ 16'h0001, 1'b0, 1'b0, "t6.change");
    chk("t6.err_set", b17.o_error, EXP_ERR);
    cyc17(1'b1, beat17(4, 8), 1'b1, 1'b1, "t6.accept");
    chk("t6.err_sticky", b17.o_error, EXP_ERR);
    chk("t6.v4_data", b17.o_data, vec17(4));
    cyc17(1'b0, '0, 1'b1, 1'b1, "t6.idle");
    chk("t6.err_sticky2", b17.o_error, EXP_ERR);

    // Reset mid-vector, with a beat offered in the reset cycle
    for (int b = 0; b < 5; b++) cyc17(1'b1, beat17(5, b), 1'b1, 1'b1, "t5.part");
    rst = 1'b1;
    b17.i_valid = 1'b1;
    b17.i_data  = beat17(5, 5);
    b17.o_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5.rst_valid", b17.o_valid, 1'b0);
    chk("t5.rst_data", b17.o_data, '0);
    chk("t5.rst_error", b17.o_error, 1'b0);
    for (int b = 0; b < 9; b++) begin
      cyc17(1'b1, beat17(6, b), 1'b1, 1'b1, "t5.v6");
      if (b < 8) chk("t5.o_valid_early", b17.o_valid, 1'b0);
    end
    chk("t5.v6_valid", b17.o_valid, 1'b1);
    chk("t5.v6_data", b17.o_data, vec17(6));
    cyc17(1'b0, '0, 1'b1, 1'b1, "t5.idle");

    // 16ch/4 lanes: two back-to-back vectors, never stalls
    for (int b = 0; b < 8; b++) begin
      b16.i_valid = 1'b1;
      b16.i_data  = beat16(b / 4, b % 4);
      b16.o_ready = 1'b1;
      @(negedge clk);
      chk("t2.i_ready", b16.i_ready, 1'b1);
      @(posedge clk);
      #1;
      chk("t2.o_valid", b16.o_valid, (b % 4 == 3) ? 1'b1 : 1'b0);
      if (b % 4 == 3) chk("t2.o_data", b16.o_data, vec16(b / 4));
    end
    b16.i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t2.drained", b16.o_valid, 1'b0);

    // Single-beat shape: registered stage honouring o_ready
    for (int i = 0; i < 10; i++) begin
      b4.i_valid = tbl[i].vld;
      b4.i_data  = tbl[i].dat;
      b4.o_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("t4.row%0d.i_ready", i), b4.i_ready, tbl[i].exp_irdy);
      @(posedge clk);
      #1;
      chk($sformatf("t4.row%0d.o_valid", i), b4.o_valid, tbl[i].exp_ovld);
      chk($sformatf("t4.row%0d.o_data", i), b4.o_data, tbl[i].exp_dat);
    end
    chk("t4.no_error", b4.o_error, 1'b0);
    chk("t2.no_error", b16.o_error, 1'b0);

    idle_all();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
